vram_access_scheduler: RTL

// - Upstream of the SDRAM memory controller: arbitrates the video fetch port, the CPU port and periodic refresh.
// - Issues one read/write/refresh pulse per controller operation and routes read data back to the owning port.
// - Owns the refresh timing budget so that no requester has to track controller busy or refresh state.

---
 rtl/vram_sched_pkg.sv | 24 ++
 rtl/refresh_timer.sv | 47 ++++
 rtl/vram_access_scheduler.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/vram_sched_pkg.sv
// Shared types and widths for the VRAM access scheduler.
`default_nettype none

package vram_sched_pkg;

    localparam int ADDR_W = 22;
    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUED = 2'd1,
        WAIT   = 2'd2
    } sched_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        VID  = 2'd1,
        CPU  = 2'd2,
        REF  = 2'd3
    } owner_t;

endpackage

`default_nettype wire

// File: rtl/refresh_timer.sv
// Refresh interval timer with a saturating refresh-debt counter and a sticky overrun flag.
`default_nettype none

module refresh_timer #(
    parameter int REFRESH_CYCLES = 416,
    parameter int MAX_PENDING    = 8,
    localparam int DEBT_W        = $clog2(MAX_PENDING + 1),
    localparam int TIMER_W       = $clog2(REFRESH_CYCLES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              consume,
    output logic [DEBT_W-1:0] debt,
    output logic              urgent,
    output logic              overrun
);

    logic [TIMER_W-1:0] r_timer;
    logic               w_tick;
    logic               w_saturated;

    assign w_tick      = (r_timer == TIMER_W'(REFRESH_CYCLES - 1));
    assign w_saturated = (debt == DEBT_W'(MAX_PENDING));
    assign urgent      = w_saturated;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
            debt    <= '0;
            overrun <= 1'b0;
        end else begin
            r_timer <= w_tick ? '0 : r_timer + TIMER_W'(1);
            if (w_tick && w_saturated) begin
                overrun <= 1'b1;
            end
            // A tick and a refresh in the same cycle cancel each other out.
            if (w_tick && !consume && !w_saturated) begin
                debt <= debt + DEBT_W'(1);
            end else if (!w_tick && consume && debt != '0) begin
                debt <= debt - DEBT_W'(1);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/vram_access_scheduler.sv
// Arbitrates video, CPU and refresh onto the SDRAM controller and returns read data to the owning port.
`default_nettype none

module vram_access_scheduler
    import vram_sched_pkg::*;
#(
    parameter int REFRESH_CYCLES   = 416,
    parameter int MAX_PENDING      = 8,
    parameter int CPU_STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_rvalid,
    output logic [DATA_W-1:0] vid_rdata,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [1:0]        cpu_wdm,
    output logic              cpu_ack,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic [1:0]        mem_wdm,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_busy,
    output logic              refresh_overrun
);

    localparam int DEBT_W   = $clog2(MAX_PENDING + 1);
    localparam int STARVE_W = $clog2(CPU_STARVE_LIMIT + 1);

    sched_state_t          r_state;
    sched_state_t          w_next_state;
    owner_t                r_owner;
    owner_t                w_grant;
    logic                  r_is_write;
    logic [STARVE_W-1:0]   r_starve_cnt;
    logic [DEBT_W-1:0]     w_debt;
    logic                  w_urgent;
    logic                  w_done;
    logic                  w_vid_ret;
    logic                  w_cpu_ret;
    logic                  w_cpu_forced;

    refresh_timer #(
        .REFRESH_CYCLES (REFRESH_CYCLES),
        .MAX_PENDING    (MAX_PENDING)
    ) u_refresh_timer (
        .clk     (clk),
        .reset   (reset),
        .consume (w_grant == REF),
        .debt    (w_debt),
        .urgent  (w_urgent),
        .overrun (refresh_overrun)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_grant != NONE) w_next_state = ISSUED;
            ISSUED:  w_next_state = WAIT;
            WAIT:    if (!mem_busy) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_cpu_forced = cpu_req && (r_starve_cnt == STARVE_W'(CPU_STARVE_LIMIT));

    always_comb begin
        w_grant   = NONE;
        if (r_state == IDLE && !mem_busy) begin
            if (w_urgent)            w_grant = REF;
            else if (w_cpu_forced)   w_grant = CPU;
            else if (vid_req)        w_grant = VID;
            else if (cpu_req)        w_grant = CPU;
            else if (w_debt != '0)   w_grant = REF;
        end
        w_done    = (r_state == WAIT) && !mem_busy;
        w_vid_ret = w_done && (r_owner == VID);
        w_cpu_ret = w_done && (r_owner == CPU) && !r_is_write;
    end

    // Every command, ack and address is registered so the controller sees a clean pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read     <= 1'b0;
            mem_write    <= 1'b0;
            mem_refresh  <= 1'b0;
            mem_addr     <= '0;
            mem_din      <= '0;
            mem_wdm      <= '0;
            vid_ack      <= 1'b0;
            cpu_ack      <= 1'b0;
            vid_rvalid   <= 1'b0;
            cpu_rvalid   <= 1'b0;
            vid_rdata    <= '0;
            cpu_rdata    <= '0;
            r_owner      <= NONE;
            r_is_write   <= 1'b0;
            r_starve_cnt <= '0;
        end else begin
            mem_read    <= (w_grant == VID) || ((w_grant == CPU) && !cpu_wr);
            mem_write   <= (w_grant == CPU) && cpu_wr;
            mem_refresh <= (w_grant == REF);
            vid_ack     <= (w_grant == VID);
            cpu_ack     <= (w_grant == CPU);
            vid_rvalid  <= w_vid_ret;
            cpu_rvalid  <= w_cpu_ret;
            if (w_vid_ret) vid_rdata <= mem_dout;
            if (w_cpu_ret) cpu_rdata <= mem_dout;

            if (w_grant != NONE) begin
                r_owner    <= w_grant;
                r_is_write <= (w_grant == CPU) && cpu_wr;
                case (w_grant)
                    VID: begin
                        mem_addr <= vid_addr;
                        mem_din  <= '0;
                        mem_wdm  <= '0;
                    end
                    CPU: begin
                        mem_addr <= cpu_addr;
                        mem_din  <= cpu_wdata;
                        mem_wdm  <= cpu_wr ? cpu_wdm : 2'b00;
                    end
                    default: begin
                        mem_addr <= '0;
                        mem_din  <= '0;
                        mem_wdm  <= '0;
                    end
                endcase
            end

            if (w_grant == CPU) begin
                r_starve_cnt <= '0;
            end else if ((w_grant == VID) && cpu_req &&
                         (r_starve_cnt != STARVE_W'(CPU_STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + STARVE_W'(1);
            end
        end
    end

endmodule

`default_nettype wire
